// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order tag allocation, CDB capture, in-order
// retire with mispredict squash, operand read with CDB bypass, halt state.
module rob_nway #(
   parameter int ROB_DEPTH = 32,
   parameter int DP_WIDTH  = 3,
   parameter int RT_WIDTH  = 3,
   parameter int CDB_WIDTH = 3,
   parameter int XLEN      = 32,
   parameter int REG_W     = 5,
   localparam int TAG_W    = $clog2(ROB_DEPTH),
   localparam int FW       = $clog2(DP_WIDTH+1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           squash_in,
   input  logic [DP_WIDTH-1:0]            dp_valid,
   input  logic [DP_WIDTH-1:0]            dp_dest_valid,
   input  logic [DP_WIDTH*REG_W-1:0]      dp_dest_idx,
   output logic [FW-1:0]                  dp_free,
   output logic [DP_WIDTH*TAG_W-1:0]      dp_tag,
   input  logic [2*DP_WIDTH*TAG_W-1:0]    src_tag,
   input  logic [2*DP_WIDTH-1:0]          src_tag_valid,
   output logic [2*DP_WIDTH-1:0]          src_ready,
   output logic [2*DP_WIDTH*XLEN-1:0]     src_value,
   input  logic [CDB_WIDTH-1:0]           cdb_valid,
   input  logic [CDB_WIDTH*TAG_W-1:0]     cdb_tag,
   input  logic [CDB_WIDTH*XLEN-1:0]      cdb_value,
   input  logic [CDB_WIDTH-1:0]           cdb_mispredict,
   input  logic [CDB_WIDTH*XLEN-1:0]      cdb_npc,
   input  logic [CDB_WIDTH-1:0]           cdb_halt,
   output logic [RT_WIDTH-1:0]            rt_valid,
   output logic [RT_WIDTH*REG_W-1:0]      rt_dest_idx,
   output logic [RT_WIDTH*XLEN-1:0]       rt_value,
   output logic                           rt_squash,
   output logic [XLEN-1:0]                rt_npc,
   output logic                           halted
);

   localparam int CW = TAG_W + 1;
   localparam int RW = $clog2(RT_WIDTH+1);

   typedef enum logic {RUN, HALTED} state_t;
   state_t state, state_nx;

   logic [ROB_DEPTH-1:0] busy, done, misp, hlt;
   logic [REG_W-1:0]     dest  [ROB_DEPTH];
   logic [XLEN-1:0]      value [ROB_DEPTH];
   logic [XLEN-1:0]      npc   [ROB_DEPTH];
   logic [TAG_W-1:0]     head, tail;
   logic [CW-1:0]        count, space;
   logic [DP_WIDTH-1:0]  acc;
   logic [FW-1:0]        n_acc;
   logic [RW-1:0]        n_ret;
   logic                 hit_halt, flush;

   assign space  = CW'(ROB_DEPTH) - count;
   assign halted = (state == HALTED);
   assign flush  = rt_squash | squash_in;

   // free slots come from the registered count only
   always_comb begin
      dp_free = '0;
      if (state == RUN && !squash_in) begin
         if (space >= CW'(DP_WIDTH)) dp_free = FW'(DP_WIDTH);
         else                        dp_free = FW'(space);
      end
   end

   always_comb begin
      acc    = '0;
      n_acc  = '0;
      dp_tag = '0;
      for (int i = 0; i < DP_WIDTH; i++) begin
         dp_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
         if (dp_valid[i] && FW'(i) < dp_free) begin
            acc[i] = 1'b1;
            n_acc  = n_acc + FW'(1);
         end
      end
   end

   // a mispredicting or halting entry is the last to retire in its cycle
   always_comb begin
      logic             stop;
      logic [TAG_W-1:0] idx;
      stop        = (state != RUN);
      idx         = head;
      rt_valid    = '0;
      rt_dest_idx = '0;
      rt_value    = '0;
      rt_squash   = 1'b0;
      rt_npc      = '0;
      n_ret       = '0;
      hit_halt    = 1'b0;
      for (int j = 0; j < RT_WIDTH; j++) begin
         idx = head + TAG_W'(j);
         if (!stop && busy[idx] && done[idx]) begin
            rt_valid[j] = 1'b1;
            rt_dest_idx[j*REG_W +: REG_W] = dest[idx];
            rt_value[j*XLEN +: XLEN]      = value[idx];
            n_ret = n_ret + RW'(1);
            if (misp[idx]) begin
               rt_squash = 1'b1;
               rt_npc    = npc[idx];
            end
            if (hlt[idx]) hit_halt = 1'b1;
            stop = misp[idx] | hlt[idx];
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_comb begin
      logic [TAG_W-1:0] t;
      t         = '0;
      src_ready = '0;
      src_value = '0;
      for (int s = 0; s < 2*DP_WIDTH; s++) begin
         t = src_tag[s*TAG_W +: TAG_W];
         if (src_tag_valid[s]) begin
            src_ready[s] = done[t];
            src_value[s*XLEN +: XLEN] = value[t];
            for (int c = 0; c < CDB_WIDTH; c++) begin
               if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
                  src_ready[s] = 1'b1;
                  src_value[s*XLEN +: XLEN] = cdb_value[c*XLEN +: XLEN];
               end
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      if (state == RUN && hit_halt) state_nx = HALTED;
   end

   always_ff @(posedge clock) begin
      if (!reset) state <= RUN;
      else        state <= state_nx;
      if (!reset || flush) begin
         busy  <= '0;
         done  <= '0;
         misp  <= '0;
         hlt   <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < ROB_DEPTH; e++) begin
            dest[e]  <= '0;
            value[e] <= '0;
            npc[e]   <= '0;
         end
      end else begin
         if (state == RUN) begin
            for (int c = 0; c < CDB_WIDTH; c++) begin
               if (cdb_valid[c] && busy[cdb_tag[c*TAG_W +: TAG_W]]) begin
                  done[cdb_tag[c*TAG_W +: TAG_W]]  <= 1'b1;
                  value[cdb_tag[c*TAG_W +: TAG_W]] <= cdb_value[c*XLEN +: XLEN];
                  misp[cdb_tag[c*TAG_W +: TAG_W]]  <= cdb_mispredict[c];
                  npc[cdb_tag[c*TAG_W +: TAG_W]]   <= cdb_npc[c*XLEN +: XLEN];
                  hlt[cdb_tag[c*TAG_W +: TAG_W]]   <= cdb_halt[c];
               end
            end
         end
         for (int j = 0; j < RT_WIDTH; j++) begin
            if (rt_valid[j]) begin
               busy[head + TAG_W'(j)] <= 1'b0;
               done[head + TAG_W'(j)] <= 1'b0;
            end
         end
         for (int i = 0; i < DP_WIDTH; i++) begin
            if (acc[i]) begin
               busy[tail + TAG_W'(i)] <= 1'b1;
               done[tail + TAG_W'(i)] <= 1'b0;
               dest[tail + TAG_W'(i)] <= dp_dest_valid[i] ?
                  dp_dest_idx[i*REG_W +: REG_W] : '0;
            end
         end
         head  <= head + TAG_W'(n_ret);
         tail  <= tail + TAG_W'(n_acc);
         count <= count + CW'(n_acc) - CW'(n_ret);
      end
   end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed scenarios plus random traffic checked
// against a program-order queue model of the buffer.
module tb_rob_nway;

   localparam int D = 32;

   logic         clock, reset, squash_in;
   logic [2:0]   dp_valid, dp_dest_valid;
   logic [14:0]  dp_dest_idx;
   logic [1:0]   dp_free;
   logic [14:0]  dp_tag;
   logic [29:0]  src_tag;
   logic [5:0]   src_tag_valid, src_ready;
   logic [191:0] src_value;
   logic [2:0]   cdb_valid, cdb_mispredict, cdb_halt;
   logic [14:0]  cdb_tag;
   logic [95:0]  cdb_value, cdb_npc;
   logic [2:0]   rt_valid;
   logic [14:0]  rt_dest_idx;
   logic [95:0]  rt_value;
   logic         rt_squash;
   logic [31:0]  rt_npc;
   logic         halted;

   rob_nway dut (
      .clock(clock), .reset(reset), .squash_in(squash_in),
      .dp_valid(dp_valid), .dp_dest_valid(dp_dest_valid),
      .dp_dest_idx(dp_dest_idx), .dp_free(dp_free), .dp_tag(dp_tag),
      .src_tag(src_tag), .src_tag_valid(src_tag_valid),
      .src_ready(src_ready), .src_value(src_value),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_npc(cdb_npc),
      .cdb_halt(cdb_halt), .rt_valid(rt_valid),
      .rt_dest_idx(rt_dest_idx), .rt_value(rt_value),
      .rt_squash(rt_squash), .rt_npc(rt_npc), .halted(halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  dest;
      logic        done;
      logic [31:0] val;
      logic        misp;
      logic [31:0] npc;
      logic        halt;
   } ent_t;

   // model: in-flight instructions oldest first; q[k] holds tag m_head+k
   ent_t q[$];
   int   m_head;
   bit   m_halted;

   int           e_free, e_nacc, e_nret;
   logic [14:0]  e_tag, e_rtd;
   logic [2:0]   e_rtv;
   logic [95:0]  e_rtval;
   logic         e_sq, e_hh;
   logic [31:0]  e_npc;
   logic [5:0]   e_rdy;
   logic [191:0] e_sval, e_smask;

   int n_cmp, n_err;

   task automatic predict();
      int sz;
      int k;
      bit hit;
      sz = q.size();
      e_free = D - sz;
      if (e_free > 3) e_free = 3;
      if (m_halted || squash_in) e_free = 0;
      e_nacc = 0;
      for (int i = 0; i < 3; i++) begin
         if (dp_valid[i] && i < e_free) e_nacc++;
         e_tag[i*5 +: 5] = 5'((m_head + sz + i) % D);
      end
      e_rtv = '0; e_rtd = '0; e_rtval = '0;
      e_sq = 1'b0; e_npc = '0; e_hh = 1'b0; e_nret = 0;
      if (!m_halted) begin
         for (int j = 0; j < 3; j++) begin
            if (j < sz && q[j].done) begin
               e_rtv[j] = 1'b1;
               e_rtd[j*5 +: 5] = q[j].dest;
               e_rtval[j*32 +: 32] = q[j].val;
               e_nret++;
               if (q[j].misp) begin e_sq = 1'b1; e_npc = q[j].npc; end
               if (q[j].halt) e_hh = 1'b1;
               if (q[j].misp || q[j].halt) break;
            end else break;
         end
      end
      e_rdy = '0; e_sval = '0; e_smask = '1;
      for (int s = 0; s < 6; s++) begin
         if (src_tag_valid[s]) begin
            hit = 0;
            for (int c = 0; c < 3; c++) begin
               if (cdb_valid[c] && cdb_tag[c*5 +: 5] == src_tag[s*5 +: 5]) begin
                  hit = 1;
                  e_sval[s*32 +: 32] = cdb_value[c*32 +: 32];
               end
            end
            k = (int'(src_tag[s*5 +: 5]) - m_head + D) % D;
            if (hit) e_rdy[s] = 1'b1;
            else if (k < sz && q[k].done) begin
               e_rdy[s] = 1'b1;
               e_sval[s*32 +: 32] = q[k].val;
            end else e_smask[s*32 +: 32] = '0;
         end
      end
   endtask

   task automatic update();
      bit   was;
      int   k;
      ent_t t;
      if (!reset) begin
         q.delete(); m_head = 0; m_halted = 0;
         return;
      end
      was = m_halted;
      if (e_hh) m_halted = 1;
      if (e_sq || squash_in) begin
         q.delete(); m_head = 0;
         return;
      end
      if (!was) begin
         for (int c = 0; c < 3; c++) begin
            k = (int'(cdb_tag[c*5 +: 5]) - m_head + D) % D;
            if (cdb_valid[c] && k < q.size()) begin
               t = q[k];
               t.done = 1'b1;
               t.val  = cdb_value[c*32 +: 32];
               t.misp = cdb_mispredict[c];
               t.npc  = cdb_npc[c*32 +: 32];
               t.halt = cdb_halt[c];
               q[k] = t;
            end
         end
      end
      repeat (e_nret) void'(q.pop_front());
      m_head = (m_head + e_nret) % D;
      for (int i = 0; i < e_nacc; i++) begin
         t = '0;
         t.dest = dp_dest_valid[i] ? dp_dest_idx[i*5 +: 5] : 5'd0;
         q.push_back(t);
      end
   endtask

   task automatic idle();
      squash_in = 0; dp_valid = 0; dp_dest_valid = 0; dp_dest_idx = 0;
      src_tag = 0; src_tag_valid = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
      cdb_mispredict = 0; cdb_npc = 0; cdb_halt = 0;
   endtask

   task automatic eval();
      #1;
      predict();
   endtask

   task automatic tick();
      predict();
      @(posedge clock);
      update();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 0;
      idle();
      tick();
      tick();
      reset = 1;
   endtask

   task automatic set_dp(input logic [2:0] v);
      dp_valid = v;
      dp_dest_valid = v;
      for (int i = 0; i < 3; i++)
         dp_dest_idx[i*5 +: 5] = 5'(((m_head + q.size() + i) % D) % 31 + 1);
   endtask

   task automatic set_cdb(input int ln, input int tg, input logic [31:0] v,
                          input bit mp, input logic [31:0] np, input bit h);
      cdb_valid[ln] = 1'b1;
      cdb_tag[ln*5 +: 5] = 5'(tg);
      cdb_value[ln*32 +: 32] = v;
      cdb_mispredict[ln] = mp;
      cdb_npc[ln*32 +: 32] = np;
      cdb_halt[ln] = h;
   endtask

   task automatic test_reset();
      do_reset();
      src_tag_valid = '1;
      eval();
      n_cmp++; if (dp_free !== 2'd3) begin n_err++; $display("FAIL reset_free got %0d exp 3", dp_free); end
      n_cmp++; if (rt_valid !== 3'b000) begin n_err++; $display("FAIL reset_rtv got %b exp 000", rt_valid); end
      n_cmp++; if (rt_squash !== 1'b0 || rt_npc !== 32'd0) begin n_err++; $display("FAIL reset_squash got %b/%h exp 0/0", rt_squash, rt_npc); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
      n_cmp++; if (src_ready !== 6'd0) begin n_err++; $display("FAIL reset_srcrdy got %b exp 0", src_ready); end
      idle();
   endtask

   task automatic test_dispatch();
      do_reset();
      set_dp(3'b111);
      eval();
      n_cmp++; if (dp_tag !== {5'd2, 5'd1, 5'd0}) begin n_err++; $display("FAIL disp_tag got %h exp 0820", dp_tag); end
      tick();
      idle();
      eval();
      n_cmp++; if (dp_free !== 2'd3) begin n_err++; $display("FAIL disp_free got %0d exp 3", dp_free); end
      n_cmp++; if (dp_tag[4:0] !== 5'd3) begin n_err++; $display("FAIL disp_tail got %0d exp 3", dp_tag[4:0]); end
   endtask

   task automatic test_fill_wrap();
      do_reset();
      for (int n = 0; n < 11; n++) begin set_dp(3'b111); tick(); end
      set_dp(3'b111);
      eval();
      n_cmp++; if (dp_free !== 2'd0) begin n_err++; $display("FAIL full_free got %0d exp 0", dp_free); end
      tick();
      idle();
      set_dp(3'b111);
      set_cdb(0, 0, 32'hA0, 0, 0, 0);
      set_cdb(1, 1, 32'hA1, 0, 0, 0);
      set_cdb(2, 2, 32'hA2, 0, 0, 0);
      tick();
      idle();
      set_dp(3'b111);
      eval();
      n_cmp++; if (rt_valid !== 3'b111) begin n_err++; $display("FAIL full_rtv got %b exp 111", rt_valid); end
      n_cmp++; if (rt_dest_idx !== {5'd3, 5'd2, 5'd1}) begin n_err++; $display("FAIL full_rtd got %h exp 0c41", rt_dest_idx); end
      n_cmp++; if (rt_value !== {32'hA2, 32'hA1, 32'hA0}) begin n_err++; $display("FAIL full_rtval got %h", rt_value); end
      n_cmp++; if (dp_free !== 2'd0) begin n_err++; $display("FAIL full_rt_free got %0d exp 0", dp_free); end
      tick();
      idle();
      eval();
      n_cmp++; if (dp_free !== 2'd3) begin n_err++; $display("FAIL wrap_free got %0d exp 3", dp_free); end
      n_cmp++; if (dp_tag !== {5'd2, 5'd1, 5'd0}) begin n_err++; $display("FAIL wrap_tag got %h exp 0820", dp_tag); end
   endtask

   task automatic test_partial();
      do_reset();
      set_dp(3'b111);
      tick();
      idle();
      set_cdb(0, 2, 32'h22, 0, 0, 0);
      tick();
      idle();
      eval();
      n_cmp++; if (rt_valid !== 3'b000) begin n_err++; $display("FAIL part_none got %b exp 000", rt_valid); end
      set_cdb(1, 0, 32'h20, 0, 0, 0);
      tick();
      idle();
      eval();
      n_cmp++; if (rt_valid !== 3'b001) begin n_err++; $display("FAIL part_one got %b exp 001", rt_valid); end
      n_cmp++; if (rt_value[31:0] !== 32'h20) begin n_err++; $display("FAIL part_val got %h exp 20", rt_value[31:0]); end
   endtask

   task automatic test_mispredict();
      do_reset();
      set_dp(3'b111);
      tick();
      idle();
      set_cdb(0, 0, 32'h10, 0, 0, 0);
      set_cdb(1, 1, 32'h11, 1, 32'h40, 0);
      set_cdb(2, 2, 32'h12, 0, 0, 0);
      tick();
      idle();
      set_dp(3'b111);
      eval();
      n_cmp++; if (rt_valid !== 3'b011) begin n_err++; $display("FAIL misp_rtv got %b exp 011", rt_valid); end
      n_cmp++; if (rt_squash !== 1'b1 || rt_npc !== 32'h40) begin n_err++; $display("FAIL misp_sq got %b/%h exp 1/40", rt_squash, rt_npc); end
      tick();
      idle();
      eval();
      n_cmp++; if (dp_free !== 2'd3 || dp_tag !== {5'd2, 5'd1, 5'd0}) begin n_err++; $display("FAIL misp_flush got %0d/%h exp 3/0820", dp_free, dp_tag); end
      n_cmp++; if (rt_valid !== 3'b000 || rt_squash !== 1'b0) begin n_err++; $display("FAIL misp_after got %b/%b exp 000/0", rt_valid, rt_squash); end
   endtask

   task automatic test_bypass();
      do_reset();
      set_dp(3'b111); tick();
      set_dp(3'b111); tick();
      idle();
      set_cdb(0, 5, 32'hDEAD, 0, 0, 0);
      src_tag[4:0] = 5'd5;  src_tag_valid[0] = 1;
      src_tag[9:5] = 5'd4;  src_tag_valid[1] = 1;
      src_tag[14:10] = 5'd5; src_tag_valid[2] = 0;
      eval();
      n_cmp++; if (src_ready[0] !== 1'b1 || src_value[31:0] !== 32'hDEAD) begin n_err++; $display("FAIL byp_hit got %b/%h exp 1/dead", src_ready[0], src_value[31:0]); end
      n_cmp++; if (src_ready[1] !== 1'b0) begin n_err++; $display("FAIL byp_miss got %b exp 0", src_ready[1]); end
      n_cmp++; if (src_ready[2] !== 1'b0 || src_value[95:64] !== 32'd0) begin n_err++; $display("FAIL byp_inval got %b/%h exp 0/0", src_ready[2], src_value[95:64]); end
      tick();
      cdb_valid = 0;
      eval();
      n_cmp++; if (src_ready[0] !== 1'b1 || src_value[31:0] !== 32'hDEAD) begin n_err++; $display("FAIL byp_reg got %b/%h exp 1/dead", src_ready[0], src_value[31:0]); end
      idle();
   endtask

   task automatic test_halt();
      do_reset();
      set_dp(3'b111); tick();
      set_dp(3'b111); tick();
      idle();
      set_cdb(0, 0, 32'h30, 0, 0, 0);
      set_cdb(1, 1, 32'h31, 0, 0, 1);
      set_cdb(2, 2, 32'h32, 0, 0, 0);
      tick();
      idle();
      set_cdb(0, 3, 32'h33, 0, 0, 0);
      set_cdb(1, 4, 32'h34, 0, 0, 0);
      eval();
      n_cmp++; if (rt_valid !== 3'b011 || halted !== 1'b0) begin n_err++; $display("FAIL halt_rt got %b/%b exp 011/0", rt_valid, halted); end
      tick();
      idle();
      for (int n = 0; n < 3; n++) begin
         set_cdb(0, 5, 32'h35, 0, 0, 0);
         set_dp(3'b111);
         eval();
         n_cmp++; if (halted !== 1'b1 || rt_valid !== 3'b000 || dp_free !== 2'd0) begin n_err++; $display("FAIL halt_hold got %b/%b/%0d exp 1/000/0", halted, rt_valid, dp_free); end
         tick();
      end
      reset = 0;
      idle();
      tick();
      reset = 1;
      eval();
      n_cmp++; if (halted !== 1'b0 || dp_free !== 2'd3) begin n_err++; $display("FAIL halt_reset got %b/%0d exp 0/3", halted, dp_free); end
   endtask

   task automatic test_squash_in();
      do_reset();
      set_dp(3'b111); tick();
      set_dp(3'b111);
      squash_in = 1;
      eval();
      n_cmp++; if (dp_free !== 2'd0 || rt_squash !== 1'b0) begin n_err++; $display("FAIL sqin_now got %0d/%b exp 0/0", dp_free, rt_squash); end
      tick();
      idle();
      eval();
      n_cmp++; if (dp_free !== 2'd3 || dp_tag !== {5'd2, 5'd1, 5'd0}) begin n_err++; $display("FAIL sqin_after got %0d/%h exp 3/0820", dp_free, dp_tag); end
   endtask

   task automatic test_random();
      int nl;
      int tg;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         idle();
         nl = $urandom_range(0, 3);
         dp_valid = 3'((1 << nl) - 1);
         dp_dest_valid = 3'($urandom);
         dp_dest_idx = 15'($urandom);
         for (int c = 0; c < 3; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 99) < 85 && q.size() > 0)
                  tg = (m_head + $urandom_range(0, q.size() - 1)) % D;
               else
                  tg = $urandom_range(0, D - 1);
               if (!((cdb_valid[0] && int'(cdb_tag[4:0]) == tg) ||
                     (cdb_valid[1] && int'(cdb_tag[9:5]) == tg)))
                  set_cdb(c, tg, $urandom, $urandom_range(0, 19) == 0,
                          $urandom, 0);
            end
         end
         squash_in = ($urandom_range(0, 49) == 0);
         src_tag = 30'($urandom);
         src_tag_valid = 6'($urandom);
         eval();
         n_cmp++; if (dp_free !== 2'(e_free)) begin n_err++; $display("FAIL rnd_free got %0d exp %0d", dp_free, e_free); end
         n_cmp++; if (dp_tag !== e_tag) begin n_err++; $display("FAIL rnd_tag got %h exp %h", dp_tag, e_tag); end
         n_cmp++; if (rt_valid !== e_rtv) begin n_err++; $display("FAIL rnd_rtv got %b exp %b", rt_valid, e_rtv); end
         n_cmp++; if (rt_dest_idx !== e_rtd || rt_value !== e_rtval) begin n_err++; $display("FAIL rnd_rtdata got %h/%h exp %h/%h", rt_dest_idx, rt_value, e_rtd, e_rtval); end
         n_cmp++; if (rt_squash !== e_sq || rt_npc !== e_npc) begin n_err++; $display("FAIL rnd_squash got %b/%h exp %b/%h", rt_squash, rt_npc, e_sq, e_npc); end
         n_cmp++; if (halted !== m_halted) begin n_err++; $display("FAIL rnd_halted got %b exp %b", halted, m_halted); end
         n_cmp++; if (src_ready !== e_rdy) begin n_err++; $display("FAIL rnd_srcrdy got %b exp %b", src_ready, e_rdy); end
         n_cmp++; if ((src_value & e_smask) !== e_sval) begin n_err++; $display("FAIL rnd_srcval got %h exp %h", src_value & e_smask, e_sval); end
         tick();
      end
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      m_head = 0;
      m_halted = 0;
      reset = 0;
      idle();
      @(negedge clock);
      test_reset();
      test_dispatch();
      test_fill_wrap();
      test_partial();
      test_mispredict();
      test_bypass();
      test_halt();
      test_squash_in();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rob_nway.md
Name: rob_nway

Overview:
- Parametrised N-wide reorder buffer, the successor to the fixed 3-wide ROB. Sits between dispatch/map-table, the CDB and retire.
- Allocates tags in program order and captures completion results from the CDB.
- Retires up to RT_WIDTH entries in order per cycle and supplies operand values to the RS.
- Adds over the 3-wide block: exact full/empty occupancy counting, a dispatch accept handshake, same-cycle CDB bypass on operand reads, branch-mispredict squash at retire, and a HALTED state.

Parameters:
- ROB_DEPTH, 32, number of entries; power of 2, at least 4.
- DP_WIDTH, 3, dispatch lanes per cycle.
- RT_WIDTH, 3, retire lanes per cycle.
- CDB_WIDTH, 3, CDB broadcast lanes per cycle.
- XLEN, 32, data width.
- REG_W, 5, architectural register index width.
- TAG_W is derived as $clog2(ROB_DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; resets state when 0 at a posedge.
- squash_in  in  1  external flush.
- dp_valid  in  DP_WIDTH  dispatch request per lane; must be contiguous from lane 0.
- dp_dest_valid  in  DP_WIDTH  lane writes a register.
- dp_dest_idx  in  DP_WIDTH*REG_W  destination register index.
- dp_free  out  $clog2(DP_WIDTH+1)  equals min(free entries, DP_WIDTH).
- dp_tag  out  DP_WIDTH*TAG_W  tag assigned to lane i, equal to (tail+i) mod ROB_DEPTH.
- src_tag  in  2*DP_WIDTH*TAG_W  operand tags from the map table.
- src_tag_valid  in  2*DP_WIDTH  operand is renamed.
- src_ready  out  2*DP_WIDTH  operand value is available.
- src_value  out  2*DP_WIDTH*XLEN  operand value.
- cdb_valid  in  CDB_WIDTH  completion valid per lane.
- cdb_tag  in  CDB_WIDTH*TAG_W  completing tag.
- cdb_value  in  CDB_WIDTH*XLEN  result value.
- cdb_mispredict  in  CDB_WIDTH  branch resolved against its prediction.
- cdb_npc  in  CDB_WIDTH*XLEN  correct next PC.
- cdb_halt  in  CDB_WIDTH  instruction is a halt.
- rt_valid  out  RT_WIDTH  lane retires this cycle.
- rt_dest_idx  out  RT_WIDTH*REG_W  retiring destination index; 0 if no destination.
- rt_value  out  RT_WIDTH*XLEN  retiring result value.
- rt_squash  out  1  a retiring branch mispredicted.
- rt_npc  out  XLEN  redirect PC; valid when rt_squash=1.
- halted  out  1  a halt has retired.

Behaviour:
- State per entry: busy, done, dest_idx, value, mispredict, npc, halt.
- Pointers: head and tail are TAG_W bits. count is TAG_W+1 bits and ranges 0..ROB_DEPTH. Empty is count==0; full is count==ROB_DEPTH.
- Reset (reset=0 at a posedge):
  - All entries are cleared; head, tail and count are 0; FSM is RUN.
  - Outputs: rt_valid=0, rt_squash=0, rt_npc=0, halted=0, src_ready=0.
  - dp_free=min(ROB_DEPTH,DP_WIDTH) from the first cycle after reset.
  - Reset has priority over every other event, including during a mispredict retire.
- Dispatch handshake:
  - Lane i is accepted iff dp_valid[i] and i<dp_free.
  - dp_free is computed from the registered count and does not count same-cycle retirement.
  - Accepted entries are written busy=1, done=0 and dest_idx (0 if !dp_dest_valid).
  - tail advances by the number accepted, modulo ROB_DEPTH; wrap-around is natural.
  - dp_free=0 when full, when in HALTED, or when squash_in=1.
- Complete:
  - For each valid CDB lane whose tag entry is busy, set done=1 and capture value, mispredict, npc and halt.
  - A CDB write to a non-busy entry is ignored.
  - Distinct lanes never carry the same tag.
  - A completion becomes visible to retire the next cycle (registered state only).
- Retire:
  - Retire lane j is valid iff entries head..head+j are all busy and done, and no earlier lane k<j retired with mispredict or halt set.
  - head advances by the number retired; count_next = count + accepted - retired.
- Mispredict:
  - When a retiring entry has mispredict=1: rt_squash=1 and rt_npc=entry.npc combinationally in the same cycle.
  - Next cycle the block is flushed as for reset, but the FSM state is kept.
  - Dispatch accepted in that same cycle is discarded.
- squash_in: next cycle flushes as for a mispredict. rt_squash is not asserted.
- FSM:
  - RUN to HALTED when an entry with halt=1 retires.
  - HALTED: halted=1, no retirement, no dispatch, CDB writes are ignored.
  - HALTED is left only by reset.
- Operand read, per source s:
  - If !src_tag_valid: src_ready=0 and src_value=0.
  - Else if any CDB lane this cycle has a matching tag: src_ready=1 and src_value is that lane's cdb_value (bypass).
  - Else: src_ready=entry.done and src_value=entry.value.
- Simultaneous retire and dispatch on a full ROB: dispatch is refused that cycle (dp_free=0); retirement proceeds.

Test Plan:
- After reset, dispatch 3 lanes with dest 1,2,3 -> dp_tag=0,1,2. Next cycle count=3, dp_free=3.
- Fill 32 entries -> dp_free=0 and dp_valid is ignored. CDB completes tags 0,1,2 -> the cycle after, rt_valid=3'b111 and rt_dest_idx matches. The next cycle dp_free=3 and tail wraps to 0.
- Tags 0..2 dispatched; CDB completes tag 2 only -> no retire. Then tag 0 completes -> next cycle rt_valid=3'b001.
- Tag 1 completes with mispredict=1 and npc=0x40, tag 0 done, tag 2 done -> rt_valid=3'b011, rt_squash=1, rt_npc=0x40. Next cycle count=0, head=tail=0.
- src_tag=5 is valid while cdb_tag=5 and value 0xDEAD arrive in the same cycle -> src_ready=1 and src_value=0xDEAD.
- Halt at tag 1 retires -> halted=1, rt_valid=3'b011, and later completions never retire. Assert reset=0 -> next cycle halted=0 and dp_free=3.
